// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin sharing of one asynchronous-read ROM among
// NUM_REQ requesters. One read is accepted per cycle. The accepted address is
// registered onto the ROM bus, and the data is registered one cycle later
// together with a one-hot tag naming the requester.
module rom_read_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_data
);

   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   next_ptr;
   logic [ID_WIDTH-1:0]   winner;
   logic [ID_WIDTH-1:0]   scan_id;
   logic [NUM_REQ-1:0]    grant;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  found;
   logic                  accept;
   logic                  s1_valid;
   logic [ID_WIDTH-1:0]   s1_id;
   int                    idx;

   // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; the first valid one wins.
   // Nobody is granted while reset is held.
   always_comb begin
      grant   = '0;
      winner  = '0;
      scan_id = '0;
      found   = 1'b0;
      idx     = 0;
      if (!rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
               idx = idx - NUM_REQ;
            end
            scan_id = ID_WIDTH'(idx);
            if (!found && req_valid[scan_id]) begin
               found         = 1'b1;
               winner        = scan_id;
               grant[scan_id] = 1'b1;
            end
         end
      end
   end

   // Pick the winner's address slice and work out where the pointer goes after this grant.
   always_comb begin
      sel_addr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (winner == ID_WIDTH'(k)) begin
            sel_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
      if (winner == ID_WIDTH'(NUM_REQ - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = winner + 1'b1;
      end
   end

   assign req_ready = grant;
   assign accept    = found;

   // Pointer, address stage and response stage. Reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         rom_addr  <= '0;
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         if (accept) begin
            rr_ptr   <= next_ptr;
            rom_addr <= sel_addr;
            s1_id    <= winner;
         end
         s1_valid <= accept;
         if (s1_valid) begin
            rsp_data  <= rom_data;
            rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << s1_id;
         end else begin
            rsp_valid <= '0;
         end
      end
   end

endmodule
